game_state_tx: RTL and testbench

Serializes a snapshot of the local game state into a fixed 63-byte packet and transmits it over a UART 8N1 line toward the network bridge and server. It consumes the state outputs of the game logic: game state, timer, points, player pose and the object grid. It is the sending end of the state link; the server-side parser is the receiver. One packet is started per accepted `frame_update` pulse.

---
 rtl/game_state_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_game_state_tx.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_tx.sv
// rtl/game_state_tx.sv - game state snapshot serializer, 63-byte packet over UART 8N1
//
// Purpose: on an accepted frame_update, registers a snapshot of the game state and
// shifts it out as B0 = 0xA5, B1..B61 payload, B62 = XOR(B1..B61).
// Ports:
//   clock, reset (async, active-low)
//   frame_update, enable        packet request and request gate
//   local_player_ID .. object_grid  game state to snapshot
//   tx                          serial line, idles high
//   busy                        packet in flight
//   frame_sent                  one-cycle pulse at packet end
//   dropped_frames              saturating count of requests made while busy
module game_state_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_update,
    input  logic                  enable,
    input  logic [1:0]            local_player_ID,
    input  logic [2:0]            game_state,
    input  logic [1:0]            player_direction,
    input  logic [7:0]            time_left,
    input  logic [9:0]            point_total,
    input  logic [8:0]            player_loc_x,
    input  logic [8:0]            player_loc_y,
    input  logic [3:0]            player_state,
    input  logic [7:0][12:0][3:0] object_grid,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_sent,
    output logic [7:0]            dropped_frames
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [5:0]       LAST_BYTE = 6'd62;
    localparam logic [5:0]       LAST_SUM  = 6'd61;
    localparam logic [5:0]       FIRST_GRID = 6'd10;
    localparam logic [3:0]       STOP_BIT  = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              prep_q, prep_d;
    logic [5:0]        byte_idx_q, byte_idx_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        chk_q, chk_d;
    logic              tx_q, tx_d;
    logic              frame_sent_q, frame_sent_d;
    logic [7:0]        dropped_q, dropped_d;

    logic [2:0]        snap_state_q, snap_state_d;
    logic [1:0]        snap_id_q, snap_id_d;
    logic [1:0]        snap_dir_q, snap_dir_d;
    logic [7:0]        snap_time_q, snap_time_d;
    logic [9:0]        snap_points_q, snap_points_d;
    logic [8:0]        snap_x_q, snap_x_d;
    logic [8:0]        snap_y_q, snap_y_d;
    logic [3:0]        snap_pstate_q, snap_pstate_d;
    logic [415:0]      snap_grid_q, snap_grid_d;

    logic [5:0]        load_idx;
    logic [5:0]        grid_k;
    logic [7:0]        grid_pair;
    logic [7:0]        load_byte;

    // Index of the byte that will be loaded at the next byte boundary.
    always_comb begin
        load_idx = prep_q ? 6'd0 : (byte_idx_q + 6'd1);
    end

    // Packet byte mux. The flat grid holds cell n at bits [4n +: 4], so grid byte k
    // covers cells 2k (low nibble of the pair) and 2k+1; swap to put the even cell high.
    always_comb begin
        grid_k = 6'd0;
        if (load_idx >= FIRST_GRID && load_idx <= LAST_SUM) begin
            grid_k = load_idx - FIRST_GRID;
        end
        grid_pair = snap_grid_q[{grid_k, 3'b000} +: 8];
        case (load_idx)
            6'd0:    load_byte = 8'hA5;
            6'd1:    load_byte = {1'b0, snap_state_q, snap_id_q, snap_dir_q};
            6'd2:    load_byte = snap_time_q;
            6'd3:    load_byte = {6'b0, snap_points_q[9:8]};
            6'd4:    load_byte = snap_points_q[7:0];
            6'd5:    load_byte = {7'b0, snap_x_q[8]};
            6'd6:    load_byte = snap_x_q[7:0];
            6'd7:    load_byte = {7'b0, snap_y_q[8]};
            6'd8:    load_byte = snap_y_q[7:0];
            6'd9:    load_byte = {4'b0, snap_pstate_q};
            6'd62:   load_byte = chk_q;
            default: load_byte = {grid_pair[3:0], grid_pair[7:4]};
        endcase
    end

    always_comb begin
        state_d       = state_q;
        prep_d        = prep_q;
        byte_idx_d    = byte_idx_q;
        bit_idx_d     = bit_idx_q;
        cnt_d         = cnt_q;
        byte_d        = byte_q;
        chk_d         = chk_q;
        tx_d          = tx_q;
        frame_sent_d  = 1'b0;
        dropped_d     = dropped_q;
        snap_state_d  = snap_state_q;
        snap_id_d     = snap_id_q;
        snap_dir_d    = snap_dir_q;
        snap_time_d   = snap_time_q;
        snap_points_d = snap_points_q;
        snap_x_d      = snap_x_q;
        snap_y_d      = snap_y_q;
        snap_pstate_d = snap_pstate_q;
        snap_grid_d   = snap_grid_q;

        case (state_q)
            IDLE: begin
                if (frame_update && enable) begin
                    state_d       = SEND;
                    prep_d        = 1'b1;
                    chk_d         = 8'h00;
                    snap_state_d  = game_state;
                    snap_id_d     = local_player_ID;
                    snap_dir_d    = player_direction;
                    snap_time_d   = time_left;
                    snap_points_d = point_total;
                    snap_x_d      = player_loc_x;
                    snap_y_d      = player_loc_y;
                    snap_pstate_d = player_state;
                    snap_grid_d   = object_grid;
                end
            end
            SEND: begin
                if (frame_update && enable && dropped_q != 8'hFF) begin
                    dropped_d = dropped_q + 8'd1;
                end
                if (prep_q) begin
                    // First cycle after acceptance: load the sync byte, start bit begins.
                    prep_d     = 1'b0;
                    byte_idx_d = 6'd0;
                    bit_idx_d  = 4'd0;
                    cnt_d      = '0;
                    byte_d     = load_byte;
                    tx_d       = 1'b0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
                    if (bit_idx_q == STOP_BIT) begin
                        if (byte_idx_q == LAST_BYTE) begin
                            state_d      = IDLE;
                            tx_d         = 1'b1;
                            frame_sent_d = 1'b1;
                        end else begin
                            // Stop bit runs straight into the next start bit.
                            byte_idx_d = load_idx;
                            bit_idx_d  = 4'd0;
                            byte_d     = load_byte;
                            tx_d       = 1'b0;
                            if (load_idx <= LAST_SUM) begin
                                chk_d = chk_q ^ load_byte;
                            end
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : byte_q[bit_idx_q[2:0]];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            prep_q        <= 1'b0;
            byte_idx_q    <= 6'd0;
            bit_idx_q     <= 4'd0;
            cnt_q         <= '0;
            byte_q        <= 8'h00;
            chk_q         <= 8'h00;
            tx_q          <= 1'b1;
            frame_sent_q  <= 1'b0;
            dropped_q     <= 8'h00;
            snap_state_q  <= 3'd0;
            snap_id_q     <= 2'd0;
            snap_dir_q    <= 2'd0;
            snap_time_q   <= 8'd0;
            snap_points_q <= 10'd0;
            snap_x_q      <= 9'd0;
            snap_y_q      <= 9'd0;
            snap_pstate_q <= 4'd0;
            snap_grid_q   <= '0;
        end else begin
            state_q       <= state_d;
            prep_q        <= prep_d;
            byte_idx_q    <= byte_idx_d;
            bit_idx_q     <= bit_idx_d;
            cnt_q         <= cnt_d;
            byte_q        <= byte_d;
            chk_q         <= chk_d;
            tx_q          <= tx_d;
            frame_sent_q  <= frame_sent_d;
            dropped_q     <= dropped_d;
            snap_state_q  <= snap_state_d;
            snap_id_q     <= snap_id_d;
            snap_dir_q    <= snap_dir_d;
            snap_time_q   <= snap_time_d;
            snap_points_q <= snap_points_d;
            snap_x_q      <= snap_x_d;
            snap_y_q      <= snap_y_d;
            snap_pstate_q <= snap_pstate_d;
            snap_grid_q   <= snap_grid_d;
        end
    end

    assign tx             = tx_q;
    assign busy           = (state_q == SEND);
    assign frame_sent     = frame_sent_q;
    assign dropped_frames = dropped_q;

endmodule

// File: tb/tb_game_state_tx.sv
// tb/tb_game_state_tx.sv - self-checking bench for game_state_tx
module tb_game_state_tx;

    localparam int CPB     = 4;
    localparam int PKT_CYC = 630 * CPB;

    logic                  clock = 1'b0;
    logic                  clk_en = 1'b0;
    logic                  reset = 1'b1;
    logic                  frame_update = 1'b0;
    logic                  enable = 1'b0;
    logic [1:0]            local_player_ID = '0;
    logic [2:0]            game_state = '0;
    logic [1:0]            player_direction = '0;
    logic [7:0]            time_left = '0;
    logic [9:0]            point_total = '0;
    logic [8:0]            player_loc_x = '0;
    logic [8:0]            player_loc_y = '0;
    logic [3:0]            player_state = '0;
    logic [7:0][12:0][3:0] object_grid = '0;
    logic                  tx;
    logic                  busy;
    logic                  frame_sent;
    logic [7:0]            dropped_frames;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] got_b [63];
    logic [7:0] exp_b [63];
    int         n_rx;
    int         framing_err = 0;

    logic [7:0] mon_data;
    logic       mon_ok;
    logic       mon_bad;

    game_state_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock            (clock),
        .reset            (reset),
        .frame_update     (frame_update),
        .enable           (enable),
        .local_player_ID  (local_player_ID),
        .game_state       (game_state),
        .player_direction (player_direction),
        .time_left        (time_left),
        .point_total      (point_total),
        .player_loc_x     (player_loc_x),
        .player_loc_y     (player_loc_y),
        .player_state     (player_state),
        .object_grid      (object_grid),
        .tx               (tx),
        .busy             (busy),
        .frame_sent       (frame_sent),
        .dropped_frames   (dropped_frames)
    );

    always #5 if (clk_en) clock = ~clock;

    // UART receiver: sample 1.5 cycles into each bit, abandon a byte on reset.
    initial begin : rx_mon
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && tx === 1'b0) begin
                mon_ok   = 1'b1;
                mon_bad  = 1'b0;
                mon_data = 8'h00;
                for (int j = 1; j <= 9 * CPB + 1; j++) begin
                    @(negedge clock);
                    if (reset !== 1'b1) begin
                        mon_ok = 1'b0;
                        break;
                    end
                    if (j % CPB == 1) begin
                        if (j / CPB == 0) begin
                            if (tx !== 1'b0) mon_bad = 1'b1;
                        end else if (j / CPB <= 8) begin
                            mon_data[j / CPB - 1] = tx;
                        end else if (tx !== 1'b1) begin
                            mon_bad = 1'b1;
                        end
                    end
                end
                if (mon_ok) begin
                    if (mon_bad) framing_err++;
                    else rx_q.push_back(mon_data);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_expected();
        logic [7:0] p [63];
        logic [7:0] c;
        for (int i = 0; i < 63; i++) p[i] = 8'h00;
        p[0] = 8'hA5;
        p[1] = {1'b0, game_state, local_player_ID, player_direction};
        p[2] = time_left;
        p[3] = {6'b0, point_total[9:8]};
        p[4] = point_total[7:0];
        p[5] = {7'b0, player_loc_x[8]};
        p[6] = player_loc_x[7:0];
        p[7] = {7'b0, player_loc_y[8]};
        p[8] = player_loc_y[7:0];
        p[9] = {4'b0, player_state};
        for (int r = 0; r < 8; r++) begin
            for (int cc = 0; cc < 13; cc++) begin
                int n;
                n = r * 13 + cc;
                if (n % 2 == 0) p[10 + n / 2][7:4] = object_grid[r][cc];
                else            p[10 + n / 2][3:0] = object_grid[r][cc];
            end
        end
        c = 8'h00;
        for (int i = 1; i <= 61; i++) c = c ^ p[i];
        p[62] = c;
        for (int i = 0; i < 63; i++) exp_q.push_back(p[i]);
    endtask

    task automatic set_golden();
        game_state       = 3'd2;
        local_player_ID  = 2'd1;
        player_direction = 2'd1;
        time_left        = 8'd150;
        point_total      = 10'h123;
        player_loc_x     = 9'd304;
        player_loc_y     = 9'd208;
        player_state     = 4'd3;
        object_grid      = '0;
        object_grid[2][0]  = 4'd1;
        object_grid[3][0]  = 4'd1;
        object_grid[6][12] = 4'd3;
    endtask

    task automatic set_random();
        game_state       = 3'($urandom);
        local_player_ID  = 2'($urandom);
        player_direction = 2'($urandom);
        time_left        = 8'($urandom);
        point_total      = 10'($urandom);
        player_loc_x     = 9'($urandom);
        player_loc_y     = 9'($urandom);
        player_state     = 4'($urandom);
        for (int r = 0; r < 8; r++)
            for (int cc = 0; cc < 13; cc++)
                object_grid[r][cc] = 4'($urandom);
    endtask

    // Accept a packet from IDLE; returns at the first negedge after the acceptance edge.
    task automatic pulse_accept();
        @(negedge clock);
        frame_update = 1'b1;
        push_expected();
        @(negedge clock);
        frame_update = 1'b0;
    endtask

    task automatic wait_sent(output int k);
        k = 1;
        while (frame_sent !== 1'b1 && k < 4000) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic pop_packet();
        n_rx = rx_q.size();
        for (int i = 0; i < 63; i++) begin
            got_b[i] = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            exp_b[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        n_tests++;
        if ({tx, busy, frame_sent, dropped_frames} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_no_clock got tx=%b busy=%b sent=%b drop=%0d required 1 0 0 0",
                     tx, busy, frame_sent, dropped_frames);
        end
        clk_en = 1'b1;
        repeat (5) @(negedge clock);
        n_tests++;
        if ({tx, busy, frame_sent, dropped_frames} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_clocked got tx=%b busy=%b sent=%b drop=%0d required 1 0 0 0",
                     tx, busy, frame_sent, dropped_frames);
        end
        reset  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_golden();
        int k;
        set_golden();
        @(negedge clock);
        frame_update = 1'b1;
        push_expected();
        @(negedge clock);
        frame_update = 1'b0;
        n_tests++;
        if ({busy, tx} !== 2'b11) begin
            n_fail++;
            $display("FAIL golden_after_E got busy=%b tx=%b required busy=1 tx=1", busy, tx);
        end
        @(negedge clock);
        n_tests++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL golden_start_bit got tx=%b required 0", tx);
        end
        k = 2;
        while (frame_sent !== 1'b1 && k < 4000) begin
            @(negedge clock);
            k++;
        end
        n_tests++;
        if (k !== PKT_CYC + 2) begin
            n_fail++;
            $display("FAIL golden_latency got %0d cycles after E+1 required %0d", k - 2, PKT_CYC);
        end
        @(negedge clock);
        n_tests++;
        if ({frame_sent, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL golden_sent_width got sent=%b busy=%b required 0 0", frame_sent, busy);
        end
        pop_packet();
        n_tests++;
        if (n_rx !== 63) begin
            n_fail++;
            $display("FAIL golden_count got %0d bytes required 63", n_rx);
        end
        for (int i = 0; i < 63; i++) begin
            n_tests++;
            if (got_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL golden_byte[%0d] got %02h required %02h", i, got_b[i], exp_b[i]);
            end
        end
        n_tests++;
        if ({got_b[0], got_b[1], got_b[23], got_b[29], got_b[55], got_b[62]} !==
            {8'hA5, 8'h25, 8'h10, 8'h01, 8'h30, 8'h52}) begin
            n_fail++;
            $display("FAIL golden_literal got %02h %02h %02h %02h %02h %02h required a5 25 10 01 30 52",
                     got_b[0], got_b[1], got_b[23], got_b[29], got_b[55], got_b[62]);
        end
    endtask

    task automatic test_snapshot();
        int k;
        set_golden();
        pulse_accept();
        k = 1;
        while (frame_sent !== 1'b1 && k < 4000) begin
            @(negedge clock);
            set_random();
            enable = 1'($urandom);
            k++;
        end
        enable = 1'b1;
        n_tests++;
        if (k !== PKT_CYC + 2) begin
            n_fail++;
            $display("FAIL snapshot_latency got %0d required %0d", k, PKT_CYC + 2);
        end
        pop_packet();
        for (int i = 0; i < 63; i++) begin
            n_tests++;
            if (got_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL snapshot_byte[%0d] got %02h required %02h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_drops();
        int k;
        set_random();
        pulse_accept();
        repeat (100) @(negedge clock);
        repeat (3) begin
            frame_update = 1'b1;
            @(negedge clock);
            frame_update = 1'b0;
            repeat (50) @(negedge clock);
        end
        wait_sent(k);
        n_tests++;
        if (k >= 4000) begin
            n_fail++;
            $display("FAIL drops_timeout got no frame_sent within %0d cycles", k);
        end
        n_tests++;
        if (dropped_frames !== 8'd3) begin
            n_fail++;
            $display("FAIL drops_count got %0d required 3", dropped_frames);
        end
        pop_packet();
        for (int i = 0; i < 63; i++) begin
            n_tests++;
            if (got_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL drops_byte[%0d] got %02h required %02h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        set_random();
        pulse_accept();
        wait_sent(k);
        set_random();
        frame_update = 1'b1;
        push_expected();
        @(negedge clock);
        frame_update = 1'b0;
        n_tests++;
        if ({busy, dropped_frames} !== {1'b1, 8'd3}) begin
            n_fail++;
            $display("FAIL b2b_accept got busy=%b drop=%0d required busy=1 drop=3", busy, dropped_frames);
        end
        for (k = 1; k < PKT_CYC + 1; k++) @(negedge clock);
        frame_update = 1'b1;
        @(negedge clock);
        frame_update = 1'b0;
        n_tests++;
        if ({frame_sent, dropped_frames} !== {1'b1, 8'd4}) begin
            n_fail++;
            $display("FAIL b2b_last_stop_drop got sent=%b drop=%0d required sent=1 drop=4",
                     frame_sent, dropped_frames);
        end
        repeat (10) @(negedge clock);
        n_tests++;
        if ({busy, tx} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_idle_after got busy=%b tx=%b required busy=0 tx=1", busy, tx);
        end
        repeat (2) begin
            pop_packet();
            for (int i = 0; i < 63; i++) begin
                n_tests++;
                if (got_b[i] !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL b2b_byte[%0d] got %02h required %02h", i, got_b[i], exp_b[i]);
                end
            end
        end
        n_tests++;
        if (rx_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_extra_bytes got %0d leftover required 0", rx_q.size());
        end
    endtask

    task automatic test_enable();
        int k;
        logic ok;
        enable = 1'b0;
        @(negedge clock);
        frame_update = 1'b1;
        @(negedge clock);
        frame_update = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        n_tests++;
        if ({ok, dropped_frames} !== {1'b1, 8'd4}) begin
            n_fail++;
            $display("FAIL enable_low got idle_ok=%b drop=%0d required 1 and 4", ok, dropped_frames);
        end
        enable = 1'b1;
        set_random();
        pulse_accept();
        repeat (700) @(negedge clock);
        enable = 1'b0;
        wait_sent(k);
        enable = 1'b1;
        n_tests++;
        if (k >= 4000) begin
            n_fail++;
            $display("FAIL enable_mid_timeout got no frame_sent within %0d cycles", k);
        end
        pop_packet();
        n_tests++;
        if (n_rx !== 63) begin
            n_fail++;
            $display("FAIL enable_mid_count got %0d bytes required 63", n_rx);
        end
        for (int i = 0; i < 63; i++) begin
            n_tests++;
            if (got_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL enable_mid_byte[%0d] got %02h required %02h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_saturate();
        int k;
        set_random();
        pulse_accept();
        repeat (10) @(negedge clock);
        frame_update = 1'b1;
        repeat (300) @(negedge clock);
        frame_update = 1'b0;
        n_tests++;
        if (dropped_frames !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate_count got %0d required 255", dropped_frames);
        end
        wait_sent(k);
        pop_packet();
        for (int i = 0; i < 63; i++) begin
            n_tests++;
            if (got_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL saturate_byte[%0d] got %02h required %02h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        set_random();
        pulse_accept();
        repeat (30 * 10 * CPB + 2) @(negedge clock);
        n_tests++;
        if ({busy, tx} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_in_b30_start got busy=%b tx=%b required busy=1 tx=0", busy, tx);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({tx, busy, dropped_frames} !== {1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL rmid_async got tx=%b busy=%b drop=%0d required 1 0 0", tx, busy, dropped_frames);
        end
        exp_q.delete();
        @(negedge clock);
        rx_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        set_random();
        pulse_accept();
        wait_sent(k);
        n_tests++;
        if (k !== PKT_CYC + 2) begin
            n_fail++;
            $display("FAIL rmid_latency got %0d required %0d", k, PKT_CYC + 2);
        end
        pop_packet();
        n_tests++;
        if (got_b[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL rmid_sync got %02h required a5", got_b[0]);
        end
        for (int i = 0; i < 63; i++) begin
            n_tests++;
            if (got_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL rmid_byte[%0d] got %02h required %02h", i, got_b[i], exp_b[i]);
            end
        end
        n_tests++;
        if (framing_err !== 0) begin
            n_fail++;
            $display("FAIL framing_errors got %0d required 0", framing_err);
        end
    endtask

    initial begin : main
        test_reset();
        test_golden();
        test_snapshot();
        test_drops();
        test_back_to_back();
        test_enable();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
